addsub_pipe: RTL and testbench
==============================

# addsub_pipe

Parametrised, pipelined two's-complement adder/subtractor with a per-transaction add/sub mode and a valid/ready handshake on both sides. The operand width is split into SEG-bit slices. Each slice is a ripple chain of full adders, and the carry is registered between slices, so the critical path is one slice rather than the whole width. It is the streaming successor to the single-cycle ripple-carry subtractor. It sits between an operand source and any consumer that can apply backpressure.

## Interface
- WIDTH, 32: operand/result width in bits.
- SEG, 8: slice width. WIDTH % SEG must be 0, otherwise elaboration fails. N = WIDTH/SEG is the number of pipeline stages; SEG = WIDTH gives N = 1.
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands present.
- in_ready  output  1  stage 0 can accept.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- mode  input  1  0 = add, 1 = subtract.
- cin  input  1  carry-in. For subtract this is the no-borrow-in bit: cin = 1 gives a - b, cin = 0 gives a - b - 1.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  sum or difference, modulo 2^WIDTH.
- cout  output  1  carry-out. For subtract, 1 = no borrow (a >= b when cin = 1).
- ovf  output  1  signed overflow.
- zero  output  1  result == 0.

## Operation
- Arithmetic: result = a + (mode ? ~b : b) + cin. Everything is computed at WIDTH+1 bits; cout is bit WIDTH.
- ovf = carry into the MSB XOR carry out of the MSB. Both carries are taken from the final slice.
- Stage k (0..N-1) does the following:
  - adds slice k of a and of b (after mode inversion), plus the registered carry from stage k-1 (stage 0 uses cin);
  - registers the slice sum, the carry out, and a running slice-zero AND;
  - delays the upper operand slices, already-finished lower result slices and mode along with the transaction (skew/deskew registers).
- Each rank has its own valid bit. Ranks hold data and valid only; there is no other state.
- Global stall: en = !out_valid || out_ready. Every rank, including the bubbles, advances only when en = 1.
- in_ready = en, combinational from out_valid/out_ready. No combinational path runs from in_valid to in_ready.
- Transfer at the input: in_valid && in_ready at a rising edge. Transfer at the output: out_valid && out_ready at a rising edge.
- Stalled behaviour: while out_valid && !out_ready, all outputs are held stable and no rank changes.
- A transfer with in_valid = 0 while en = 1 inserts a bubble (rank valid = 0).
- Results leave in acceptance order. Nothing is dropped or duplicated.

## Timing
- Reset (rst_n low, asynchronous) clears:
  - all rank valid bits;
  - out_valid = 0, result = 0, cout = 0, ovf = 0, zero = 0;
  - the data registers, to 0.
- Because out_valid = 0 during reset, in_ready = 1.
- Reset asserted mid-operation discards every in-flight transaction immediately. No stale result appears after release.
- Latency: a transaction accepted at edge t drives out_valid = 1 after edge t+N-1, provided there is no stall. For N = 1 this is after edge t.
- Each stall cycle adds one cycle to the latency of every in-flight transaction.
- Throughput: one transaction per cycle when out_ready is held at 1.
- Simultaneous output transfer and input acceptance in the same cycle is legal and required for full throughput.
- Output signals are registered (from rank N-1). in_ready is the only combinational output.
- Slice logic is a ripple chain of SEG full adders. There is no cross-slice combinational carry.

## Test plan
All scenarios use WIDTH = 32, SEG = 8 (N = 4) unless stated.
- Add wrap: a = 0xFFFF_FFFF, b = 1, mode = 0, cin = 0 -> result 0x0000_0000, cout = 1, zero = 1, ovf = 0, out_valid 4 edges after acceptance (3 edges after the accept edge).
- Subtract: a = 25, b = 7, mode = 1, cin = 1 -> result 18, cout = 1, ovf = 0, zero = 0.
- Subtract with borrow: a = 7, b = 25, mode = 1, cin = 1 -> result 0xFFFF_FFEE, cout = 0, ovf = 0.
- Signed overflow:
  - 0x7FFF_FFFF + 1 (add, cin = 0) -> 0x8000_0000, ovf = 1;
  - 0x8000_0000 - 1 (sub, cin = 1) -> 0x7FFF_FFFF, ovf = 1.
- Backpressure: 8 back-to-back random transactions, out_ready = 0 for 3 cycles mid-stream -> in_ready = 0 during the stall, outputs held stable, all 8 results correct and in order. Repeat with SEG = 32 (N = 1) and SEG = 4 (N = 8).
- Reset mid-flight: 3 transactions accepted, then rst_n pulsed low between clock edges -> out_valid = 0 and all outputs 0 immediately. After release, no output until new input arrives. The first new transaction completes with latency 4.

Source files
------------

// File: rtl/addsub_pipe.sv
// Pipelined two's-complement adder/subtractor. WIDTH is cut into SEG-bit ripple
// slices with the carry registered between slices; valid/ready on both sides.
module addsub_pipe #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int SEG_SAFE = (SEG > 0) ? SEG : 1;
  localparam int N        = WIDTH / SEG_SAFE;

  if (SEG < 1 || (WIDTH % SEG_SAFE) != 0) begin : g_bad_seg
    $error("addsub_pipe: WIDTH (%0d) must be a positive multiple of SEG (%0d)", WIDTH, SEG);
  end

  typedef struct packed {
    logic [SEG_SAFE-1:0] sum;
    logic                c_msb;  // carry into the slice MSB
    logic                cout;   // carry out of the slice MSB
  } slice_t;

  // One slice: a plain ripple chain of SEG full adders.
  function automatic slice_t ripple(input logic [SEG_SAFE-1:0] x,
                                    input logic [SEG_SAFE-1:0] y,
                                    input logic                ci);
    slice_t r;
    logic   c;
    r = '0;
    c = ci;
    for (int i = 0; i < SEG_SAFE; i++) begin
      if (i == SEG_SAFE - 1) r.c_msb = c;
      r.sum[i] = x[i] ^ y[i] ^ c;
      c        = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    r.cout = c;
    return r;
  endfunction

  // Rank k holds the transaction after slice k has been added.
  logic             v_q   [N];
  logic [WIDTH-1:0] a_q   [N];
  logic [WIDTH-1:0] b_q   [N];
  logic             m_q   [N];
  logic [WIDTH-1:0] res_q [N];
  logic             c_q   [N];
  logic             z_q   [N];
  logic             ov_q  [N];

  logic en;

  // A single global stall: the whole pipe moves only when the output rank can.
  assign en       = !v_q[N-1] || out_ready;
  assign in_ready = en;

  for (genvar k = 0; k < N; k++) begin : g_stage
    logic             v_in;
    logic             m_in;
    logic             c_in;
    logic             z_in;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] res_in;
    logic [SEG_SAFE-1:0] b_slice;
    slice_t           s;

    if (k == 0) begin : g_head
      assign v_in   = in_valid;
      assign a_in   = a;
      assign b_in   = b;
      assign m_in   = mode;
      assign c_in   = cin;
      assign z_in   = 1'b1;
      assign res_in = '0;
    end else begin : g_body
      assign v_in   = v_q[k-1];
      assign a_in   = a_q[k-1];
      assign b_in   = b_q[k-1];
      assign m_in   = m_q[k-1];
      assign c_in   = c_q[k-1];
      assign z_in   = z_q[k-1];
      assign res_in = res_q[k-1];
    end

    assign b_slice = b_in[k*SEG_SAFE +: SEG_SAFE] ^ {SEG_SAFE{m_in}};
    assign s       = ripple(a_in[k*SEG_SAFE +: SEG_SAFE], b_slice, c_in);

    // NOTE: data registers are reset too, so result/cout/ovf/zero read 0 out of
    // reset rather than whatever a dropped transaction left behind.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q[k]   <= 1'b0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        m_q[k]   <= 1'b0;
        res_q[k] <= '0;
        c_q[k]   <= 1'b0;
        z_q[k]   <= 1'b0;
        ov_q[k]  <= 1'b0;
      end else if (en) begin
        // NOTE: non-blocking so every rank samples its neighbour's pre-edge value.
        v_q[k]   <= v_in;
        a_q[k]   <= a_in;
        b_q[k]   <= b_in;
        m_q[k]   <= m_in;
        res_q[k] <= res_in;
        res_q[k][k*SEG_SAFE +: SEG_SAFE] <= s.sum;
        c_q[k]   <= s.cout;
        z_q[k]   <= z_in & (s.sum == '0);
        ov_q[k]  <= s.c_msb ^ s.cout;
      end
    end
  end

  assign out_valid = v_q[N-1];
  assign result    = res_q[N-1];
  assign cout      = c_q[N-1];
  assign ovf       = ov_q[N-1];
  assign zero      = z_q[N-1];

endmodule

// File: tb/tb_addsub_pipe.sv
// Bench for addsub_pipe: three instances (N = 4, 1, 8) checked against an
// arithmetic reference model with a scoreboard per instance.
module tb_addsub_pipe;

  localparam int ND = 3;
  localparam int W  = 32;

  typedef struct packed {
    logic [W-1:0] res;
    logic         co;
    logic         ov;
    logic         z;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic [ND-1:0]        iv, ir, ov, ordy, md, ci, co, of, zr;
  logic [ND-1:0][W-1:0] ia, ib, res;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  addsub_pipe #(.WIDTH(W), .SEG(8)) dut_n4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .a(ia[0]), .b(ib[0]),
    .mode(md[0]), .cin(ci[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .result(res[0]),
    .cout(co[0]), .ovf(of[0]), .zero(zr[0]));

  addsub_pipe #(.WIDTH(W), .SEG(32)) dut_n1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .a(ia[1]), .b(ib[1]),
    .mode(md[1]), .cin(ci[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .result(res[1]),
    .cout(co[1]), .ovf(of[1]), .zero(zr[1]));

  addsub_pipe #(.WIDTH(W), .SEG(4)) dut_n8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .a(ia[2]), .b(ib[2]),
    .mode(md[2]), .cin(ci[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .result(res[2]),
    .cout(co[2]), .ovf(of[2]), .zero(zr[2]));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int nstg(input int d);
    case (d)
      0:       return 4;
      1:       return 1;
      default: return 8;
    endcase
  endfunction

  // Reference: plain WIDTH+1-bit arithmetic and the textbook signed-overflow rule.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic m, input logic c);
    logic [W:0]   s;
    logic [W-1:0] yy;
    exp_t         e;
    yy    = m ? ~y : y;
    s     = {1'b0, x} + {1'b0, yy} + (W+1)'(c);
    e.res = s[W-1:0];
    e.co  = s[W];
    e.ov  = (x[W-1] == yy[W-1]) && (s[W-1] != x[W-1]);
    e.z   = (s[W-1:0] == '0);
    return e;
  endfunction

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Scoreboards: a transfer is decided at the negedge before the edge that
  // performs it, since inputs only change just after a rising edge.
  for (genvar g = 0; g < ND; g++) begin : g_mon
    exp_t        q[$];
    logic        stall_prev = 1'b0;
    logic [35:0] held = '0;

    always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
        q.delete();
        stall_prev = 1'b0;
      end else begin
        check($sformatf("d%0d in_ready", g), ir[g], !ov[g] || ordy[g]);
        if (stall_prev)
          check($sformatf("d%0d stall_hold", g), {ov[g], co[g], of[g], zr[g], res[g]}, held);
        if (ov[g] && ordy[g]) begin
          if (q.size() == 0) begin
            check($sformatf("d%0d spurious_out", g), 1, 0);
          end else begin
            e = q.pop_front();
            check($sformatf("d%0d result", g), res[g], e.res);
            check($sformatf("d%0d cout", g), co[g], e.co);
            check($sformatf("d%0d ovf", g), of[g], e.ov);
            check($sformatf("d%0d zero", g), zr[g], e.z);
          end
        end
        if (iv[g] && ir[g]) q.push_back(model(ia[g], ib[g], md[g], ci[g]));
        stall_prev = ov[g] && !ordy[g];
        held       = {ov[g], co[g], of[g], zr[g], res[g]};
      end
    end
  end

  function automatic int pending(input int d);
    case (d)
      0:       return g_mon[0].q.size();
      1:       return g_mon[1].q.size();
      default: return g_mon[2].q.size();
    endcase
  endfunction

  // Present one transaction and hold it until it is accepted; returns 1 ns after that edge.
  task automatic send(input int d, input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic m, input logic c);
    logic acc;
    iv[d] = 1'b1; ia[d] = x; ib[d] = y; md[d] = m; ci[d] = c;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      acc = ir[d];
      @(posedge clk);
      #1;
      if (acc) return;
    end
    check($sformatf("d%0d send_timeout", d), 0, 1);
  endtask

  task automatic drain(input int d);
    iv[d]   = 1'b0;
    ordy[d] = 1'b1;
    for (int t = 0; t < 60 && pending(d) != 0; t++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    check($sformatf("d%0d drain_pending", d), pending(d), 0);
    check($sformatf("d%0d drain_out_valid", d), ov[d], 0);
  endtask

  task automatic directed(input string tag, input int d, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic m, input logic c,
                          input logic [W-1:0] eres, input logic eco, input logic eov,
                          input logic ez);
    int lat = -1;
    ordy[d] = 1'b1;
    send(d, x, y, m, c);
    iv[d] = 1'b0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (ov[d]) begin
        lat = j;
        break;
      end
    end
    check({tag, " latency"}, lat, nstg(d) - 1);
    check({tag, " result"}, res[d], eres);
    check({tag, " cout"}, co[d], eco);
    check({tag, " ovf"}, of[d], eov);
    check({tag, " zero"}, zr[d], ez);
    @(posedge clk);
    #1;
  endtask

  task automatic backpressure(input int d);
    int n = nstg(d);
    ordy[d] = 1'b1;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(d, rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        iv[d] = 1'b0;
      end
      begin
        repeat (n + 3) @(posedge clk);
        #1 ordy[d] = 1'b0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check($sformatf("d%0d bp_in_ready", d), ir[d], 0);
          check($sformatf("d%0d bp_out_valid", d), ov[d], 1);
          @(posedge clk);
          #1;
        end
        ordy[d] = 1'b1;
      end
    join
    drain(d);
  endtask

  task automatic stream(input int d, input int count);
    bit done = 1'b0;
    fork
      begin
        for (int i = 0; i < count; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            iv[d] = 1'b0;
            @(posedge clk);
            #1;
          end
          send(d, rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        iv[d] = 1'b0;
        done  = 1'b1;
      end
      begin
        for (int t = 0; t < 5000 && !done; t++) begin
          @(posedge clk);
          #1 ordy[d] = ($urandom_range(0, 2) != 0);
        end
        ordy[d] = 1'b1;
      end
    join
    drain(d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    iv = '0; ia = '0; ib = '0; md = '0; ci = '0; ordy = '1;
    #12;
    for (int d = 0; d < ND; d++) begin
      check($sformatf("d%0d reset in_ready", d), ir[d], 1);
      check($sformatf("d%0d reset out_valid", d), ov[d], 0);
      check($sformatf("d%0d reset result", d), res[d], 0);
      check($sformatf("d%0d reset flags", d), {co[d], of[d], zr[d]}, 0);
    end
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    directed("add_wrap", 0, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    directed("sub", 0, 32'd25, 32'd7, 1'b1, 1'b1, 32'd18, 1'b1, 1'b0, 1'b0);
    directed("sub_borrow", 0, 32'd7, 32'd25, 1'b1, 1'b1, 32'hFFFF_FFEE, 1'b0, 1'b0, 1'b0);
    directed("sub_borrow_in", 0, 32'd25, 32'd7, 1'b1, 1'b0, 32'd17, 1'b1, 1'b0, 1'b0);
    directed("add_ovf", 0, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    directed("sub_ovf", 0, 32'h8000_0000, 32'd1, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    for (int d = 1; d < ND; d++) begin
      directed($sformatf("d%0d add_wrap", d), d, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0,
               32'h0000_0000, 1'b1, 1'b0, 1'b1);
      directed($sformatf("d%0d sub_ovf", d), d, 32'h8000_0000, 32'd1, 1'b1, 1'b1,
               32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    end

    for (int d = 0; d < ND; d++) backpressure(d);
    for (int d = 0; d < ND; d++) stream(d, 60);

    // Reset in the middle of traffic: three in flight, first result already showing.
    ordy[0] = 1'b1;
    for (int i = 0; i < 3; i++) send(0, rnd_op(), rnd_op(), 1'b0, 1'b0);
    iv[0] = 1'b0;
    @(posedge clk);
    #1;
    check("pre_reset out_valid", ov[0], 1);
    #1 rst_n = 1'b0;
    #1;
    for (int d = 0; d < ND; d++) begin
      check($sformatf("d%0d midreset out_valid", d), ov[d], 0);
      check($sformatf("d%0d midreset result", d), res[d], 0);
      check($sformatf("d%0d midreset flags", d), {co[d], of[d], zr[d]}, 0);
      check($sformatf("d%0d midreset in_ready", d), ir[d], 1);
    end
    #5 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_reset idle out_valid", ov[0], 0);
    end
    @(posedge clk);
    #1;
    directed("post_reset", 0, 32'd100, 32'd58, 1'b0, 1'b1, 32'd159, 1'b0, 1'b0, 1'b0);
    drain(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
